mandel_iter_engine: RTL and testbench

- Per-pixel Mandelbrot iteration engine. Accepts one complex point c = (cr, ci) in signed fixed point, together with a pixel address tag.
- Iterates z <= z^2 + c from z = 0 until |z|^2 > 4 or the iteration cap is reached.
- Returns the iteration count on a valid/ready interface.
- Sits directly upstream of colorRom255. The 32-bit iteration output feeds its iteration input, and a count equal to MAX_ITER means in-set (black).

---
 rtl/mandel_pkg.sv | 30 +++
 rtl/mandel_iter_engine_if.sv | 28 ++
 rtl/mandel_fx_mul.sv | 10 +
 rtl/mandel_iter_engine.sv | 145 ++++++++++++++
 tb/tb_mandel_iter_engine.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared defaults, fixed-point constants and FSM state type
// for the Mandelbrot iteration engine.
// Optional feature macro: MANDEL_ITER_BULB_SKIP_EN adds the BULB state.
package mandel_pkg;

  localparam int WIDTH    = 32;
  localparam int FRAC     = 28;
  localparam int MAX_ITER = 255;
  localparam int ADDR_W   = 19;

  // 1.0 in Q4.28
  localparam logic signed [WIDTH-1:0] ONE_FX = WIDTH'(1) << FRAC;

  // |z|^2 escape threshold, 4.0 at the 2*FRAC scale of a full product sum
  localparam logic signed [2*WIDTH:0] ESCAPE_WIDE = (2*WIDTH+1)'(4) << (2*FRAC);

  // 1/16 at the 2*FRAC scale, period-2 bulb radius squared
  localparam logic signed [2*WIDTH:0] BULB_R2_WIDE = (2*WIDTH+1)'(1) << (2*FRAC-4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
`ifdef MANDEL_ITER_BULB_SKIP_EN
    ,
    BULB = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/mandel_iter_engine_if.sv
// mandel_iter_engine_if: request (c, tag) and result (count, tag) handshakes.
// master = pixel source / result sink, slave = engine.
interface mandel_iter_engine_if
  import mandel_pkg::*;
#(
  parameter int P_WIDTH  = WIDTH,
  parameter int P_ADDR_W = ADDR_W
);
  logic signed [P_WIDTH-1:0] cr;
  logic signed [P_WIDTH-1:0] ci;
  logic [P_ADDR_W-1:0]       addr_in;
  logic                      start_valid;
  logic                      start_ready;
  logic [31:0]               iteration;
  logic [P_ADDR_W-1:0]       addr_out;
  logic                      done_valid;
  logic                      out_ready;

  modport master (
    output cr, ci, addr_in, start_valid, out_ready,
    input  start_ready, iteration, addr_out, done_valid
  );

  modport slave (
    input  cr, ci, addr_in, start_valid, out_ready,
    output start_ready, iteration, addr_out, done_valid
  );
endinterface

// File: rtl/mandel_fx_mul.sv
// mandel_fx_mul: signed W x W -> 2W full product, no truncation.
module mandel_fx_mul #(
  parameter int W = 32
) (
  input  logic signed [W-1:0]   i_a,
  input  logic signed [W-1:0]   i_b,
  output logic signed [2*W-1:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: one z <= z^2 + c iteration per clock until
// |z|^2 > 4 or the iteration cap, then presents the count with its tag.
// Optional feature macro: MANDEL_ITER_BULB_SKIP_EN (period-2 bulb early out).
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int P_WIDTH    = WIDTH,
  parameter int P_FRAC     = FRAC,
  parameter int P_MAX_ITER = MAX_ITER,
  parameter int P_ADDR_W   = ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  mandel_iter_engine_if.slave  bus
);

  localparam int PW = 2*P_WIDTH;
  localparam int SW = 2*P_WIDTH + 1;
  localparam logic signed [SW-1:0] L_ESC = SW'(4) << (2*P_FRAC);

  state_e r_state, w_next;

  logic signed [P_WIDTH-1:0] r_cr, r_ci, r_zr, r_zi;
  logic [31:0]               r_cnt, r_iter;
  logic [P_ADDR_W-1:0]       r_addr;

  logic signed [P_WIDTH-1:0] w_mul_zi_in;
  logic signed [PW-1:0]      w_zr2, w_zi2, w_zri;
  logic signed [SW-1:0]      w_zr2_x, w_zi2_x, w_zri_x, w_mag, w_diff, w_dbl;
  logic signed [P_WIDTH-1:0] w_zr_nx, w_zi_nx;
  logic                      w_escape, w_cap, w_bulb_in;

  // Three CALC multipliers; the zi*zi one is shared with the BULB ci*ci test.
  mandel_fx_mul #(.W(P_WIDTH)) u_mul_zr2 (.i_a(r_zr),        .i_b(r_zr),        .o_p(w_zr2));
  mandel_fx_mul #(.W(P_WIDTH)) u_mul_zi2 (.i_a(w_mul_zi_in), .i_b(w_mul_zi_in), .o_p(w_zi2));
  mandel_fx_mul #(.W(P_WIDTH)) u_mul_zri (.i_a(r_zr),        .i_b(r_zi),        .o_p(w_zri));

`ifdef MANDEL_ITER_BULB_SKIP_EN
  logic signed [P_WIDTH-1:0] w_cr1;
  logic signed [PW-1:0]      w_cr1_sq;
  logic signed [SW-1:0]      w_bulb_sum;

  // |cr| <= 2 keeps cr + 1.0 inside Q4.28
  assign w_cr1       = r_cr + ONE_FX;
  assign w_mul_zi_in = (r_state == BULB) ? r_ci : r_zi;

  mandel_fx_mul #(.W(P_WIDTH)) u_mul_bulb (.i_a(w_cr1), .i_b(w_cr1), .o_p(w_cr1_sq));

  assign w_bulb_sum = SW'(w_cr1_sq) + w_zi2_x;
  assign w_bulb_in  = (w_bulb_sum < BULB_R2_WIDE);
`else
  assign w_mul_zi_in = r_zi;
  assign w_bulb_in   = 1'b0;
`endif

  // Widen by one bit so the escape sum and difference cannot overflow.
  assign w_zr2_x = SW'(w_zr2);
  assign w_zi2_x = SW'(w_zi2);
  assign w_zri_x = SW'(w_zri);
  assign w_mag   = w_zr2_x + w_zi2_x;
  assign w_diff  = w_zr2_x - w_zi2_x;
  assign w_dbl   = w_zri_x <<< 1;

  assign w_escape = (w_mag > L_ESC);
  assign w_cap    = (r_cnt == 32'(P_MAX_ITER));

  // >>> FRAC then wrap to WIDTH is just a bit slice of the wide value
  assign w_zr_nx = w_diff[P_FRAC +: P_WIDTH] + r_cr;
  assign w_zi_nx = w_dbl [P_FRAC +: P_WIDTH] + r_ci;

  logic w_unused;
  assign w_unused = ^{w_diff[SW-1:P_FRAC+P_WIDTH], w_diff[P_FRAC-1:0],
                      w_dbl[SW-1:P_FRAC+P_WIDTH],  w_dbl[P_FRAC-1:0], w_bulb_in};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start_valid) begin
`ifdef MANDEL_ITER_BULB_SKIP_EN
        w_next = BULB;
`else
        w_next = CALC;
`endif
      end
`ifdef MANDEL_ITER_BULB_SKIP_EN
      BULB: w_next = w_bulb_in ? DONE : CALC;
`endif
      CALC: if (w_escape || w_cap) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture c/tag on accept, iterate in CALC, latch the count on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cr   <= '0;
      r_ci   <= '0;
      r_zr   <= '0;
      r_zi   <= '0;
      r_cnt  <= '0;
      r_iter <= '0;
      r_addr <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start_valid) begin
          r_cr   <= bus.cr;
          r_ci   <= bus.ci;
          r_addr <= bus.addr_in;
          r_zr   <= '0;
          r_zi   <= '0;
          r_cnt  <= '0;
        end
`ifdef MANDEL_ITER_BULB_SKIP_EN
        BULB: if (w_bulb_in) r_iter <= 32'(P_MAX_ITER);
`endif
        CALC: begin
          if (w_escape) begin
            r_iter <= r_cnt;
          end else if (w_cap) begin
            r_iter <= 32'(P_MAX_ITER);
          end else begin
            r_zr  <= w_zr_nx;
            r_zi  <= w_zi_nx;
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = (r_state == IDLE) && !rst;
  assign bus.done_valid  = (r_state == DONE) && !rst;
  assign bus.iteration   = r_iter;
  assign bus.addr_out    = r_addr;

endmodule

// File: tb/tb_mandel_iter_engine.sv
// tb_mandel_iter_engine: directed corner points plus random c in [-2,2]^2,
// checked against an iterate-until-escape reference model.
module tb_mandel_iter_engine;
  import mandel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mandel_iter_engine_if bus ();

  mandel_iter_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Plain fixed-point Mandelbrot iteration on wide integers.
  function automatic int ref_iter(input logic signed [31:0] cr, input logic signed [31:0] ci);
    logic signed [127:0] a, b, m, t;
    logic signed [31:0]  zr, zi;
    zr = 0;
    zi = 0;
    for (int k = 0; k <= MAX_ITER; k++) begin
      a = zr;
      b = zi;
      m = a*a + b*b;
      if (m > (128'sd4 <<< 56)) return k;
      if (k == MAX_ITER) return MAX_ITER;
      t  = (a*a - b*b) >>> 28;
      zr = t[31:0] + cr;
      t  = (2*a*b) >>> 28;
      zi = t[31:0] + ci;
    end
    return MAX_ITER;
  endfunction

  function automatic bit ref_bulb(input logic signed [31:0] cr, input logic signed [31:0] ci);
    logic signed [127:0] a, b;
    a = 128'(cr) + (128'sd1 <<< 28);
    b = ci;
    return (a*a + b*b) < (128'sd1 <<< 52);
  endfunction

  task automatic do_px(input logic [31:0] cr, input logic [31:0] ci,
                       input logic [18:0] addr, input int hold);
    int exp_it, exp_lat, n;
    bit seen;
    exp_it  = ref_iter(cr, ci);
    exp_lat = exp_it + 1;
`ifdef MANDEL_ITER_BULB_SKIP_EN
    if (ref_bulb(cr, ci)) begin
      exp_it  = MAX_ITER;
      exp_lat = 2;
    end else begin
      exp_lat = exp_it + 2;
    end
`endif
    chk("ready_idle", bus.start_ready, 1);
    bus.cr = cr; bus.ci = ci; bus.addr_in = addr; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    seen = 0;
    n = 0;
    for (int e = 1; e <= 300 && !seen; e++) begin
      if (e > 1) begin @(posedge clk); #1; end
      else begin @(posedge clk); #1; end
      n = e;
      if (bus.done_valid) seen = 1;
    end
    chk("done_seen", seen, 1);
    if (!seen) return;
    chk("latency", n, exp_lat);
    chk("iteration", bus.iteration, exp_it);
    chk("addr_out", bus.addr_out, addr);
    // Hold the result under backpressure while a competing request is offered.
    for (int h = 0; h < hold; h++) begin
      bus.cr = 32'h0; bus.ci = 32'h0; bus.addr_in = 19'h7FFFF; bus.start_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", bus.done_valid, 1);
      chk("bp_ready", bus.start_ready, 0);
      chk("bp_iter", bus.iteration, exp_it);
      chk("bp_addr", bus.addr_out, addr);
    end
    bus.start_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_valid", bus.done_valid, 0);
    chk("post_ready", bus.start_ready, 1);
    chk("post_addr", bus.addr_out, addr);
  endtask

  initial begin
    int highs;
    logic [31:0] rcr, rci;
    bus.cr = '0; bus.ci = '0; bus.addr_in = '0;
    bus.start_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.start_ready, 0);
    chk("rst_valid", bus.done_valid, 0);
    chk("rst_iter", bus.iteration, 0);
    chk("rst_addr", bus.addr_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel_ready", bus.start_ready, 1);

    // Directed corner points
    do_px(32'h0000_0000, 32'h0000_0000, 19'h00001, 0);
    do_px(32'h2000_0000, 32'h2000_0000, 19'h00002, 0);
    do_px(32'h2000_0000, 32'h0000_0000, 19'h00003, 0);
    do_px(32'hF000_0000, 32'h0000_0000, 19'h00004, 0);
    do_px(32'hE000_0000, 32'h0000_0000, 19'h12345, 10);

    // Reset mid-CALC aborts the pixel
    bus.cr = 32'h0; bus.ci = 32'h0; bus.addr_in = 19'h0ABCD; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", bus.start_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_iter", bus.iteration, 0);
    chk("mid_rst_addr", bus.addr_out, 0);
    chk("mid_rst_ready1", bus.start_ready, 1);
    highs = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (bus.done_valid) highs++;
    end
    chk("aborted_no_result", highs, 0);
    do_px(32'h2000_0000, 32'h2000_0000, 19'h0BEEF, 0);

    // Random points in [-2,2]^2 with random backpressure
    for (int r = 0; r < 24; r++) begin
      rcr = $urandom_range(0, 32'h4000_0000) - 32'h2000_0000;
      rci = $urandom_range(0, 32'h4000_0000) - 32'h2000_0000;
      do_px(rcr, rci, 19'($urandom_range(0, 19'h7FFFF)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
